// File: rtl/mem_pkg.sv
// Shared types and constants for the two-port byte memory arbiter.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic PORT_CPU     = 1'b0;
  localparam logic PORT_DMA     = 1'b1;
  localparam int   READ_LAT_DEF = 2;

  // Transfer attributes latched at grant; the address is kept separately
  // because its width is a module parameter.
  typedef struct packed {
    logic       port;
    logic       we;
    logic [7:0] wdata;
  } xfer_t;

endpackage

// File: rtl/mem_rr_pick.sv
// Two-input grant selection: round-robin against the last grant, or fixed
// priority to the CPU port when rr_i is low.
module mem_rr_pick
  import mem_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  input  logic rr_i,
  output logic gnt_vld_o,
  output logic gnt_port_o
);

  always_comb begin
    gnt_vld_o  = req0_i | req1_i;
    gnt_port_o = PORT_CPU;
    if (req0_i && req1_i) begin
      gnt_port_o = rr_i ? ~last_grant_i : PORT_CPU;
    end else if (req1_i) begin
      gnt_port_o = PORT_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU and DMA byte accesses onto one memory port with a fixed
// registered read latency; one done pulse per completed access.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int READ_LAT = READ_LAT_DEF,
  parameter int RR       = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [7:0]        wdata0,
  input  logic              we0,
  output logic [7:0]        rdata0,
  output logic              done0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [7:0]        wdata1,
  input  logic              we1,
  output logic [7:0]        rdata1,
  output logic              done1,
  output logic [ADDR_W-1:0] o_address,
  output logic [7:0]        o_data,
  output logic              o_we,
  input  logic [7:0]        i_data,
  output logic              busy
);

  localparam int               CNT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((READ_LAT > 1) ? READ_LAT - 1 : 0);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  xfer_t               xfer_q, xfer_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_q, last_d;
  logic [7:0]          rdata0_q, rdata0_d;
  logic [7:0]          rdata1_q, rdata1_d;
  logic                capture;
  logic                gnt_vld, gnt_port;

  mem_rr_pick u_pick (
    .req0_i       (req0),
    .req1_i       (req1),
    .last_grant_i (last_q),
    .rr_i         (RR != 0),
    .gnt_vld_o    (gnt_vld),
    .gnt_port_o   (gnt_port)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    xfer_d   = xfer_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    capture  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          last_d      = gnt_port;
          xfer_d.port = gnt_port;
          if (gnt_port == PORT_DMA) begin
            addr_d       = addr1;
            xfer_d.we    = we1;
            xfer_d.wdata = wdata1;
          end else begin
            addr_d       = addr0;
            xfer_d.we    = we0;
            xfer_d.wdata = wdata0;
          end
          state_d = BUS;
        end
      end
      BUS: begin
        if (xfer_q.we) begin
          state_d = DONE;
        end else if (READ_LAT <= 1) begin
          // Single-cycle memory: data is already valid in the address cycle.
          capture = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (capture) begin
      if (xfer_q.port == PORT_DMA) rdata1_d = i_data;
      else                         rdata0_d = i_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      xfer_q   <= '0;
      cnt_q    <= '0;
      last_q   <= PORT_DMA;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      xfer_q   <= xfer_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Strobe and done are decoded from state so reset kills them immediately.
  assign o_address = addr_q;
  assign o_we      = (state_q == BUS) && xfer_q.we;
  assign o_data    = o_we ? xfer_q.wdata : 8'h00;
  assign done0     = (state_q == DONE) && (xfer_q.port == PORT_CPU);
  assign done1     = (state_q == DONE) && (xfer_q.port == PORT_DMA);
  assign busy      = (state_q != IDLE);
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a two-stage registered memory model.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0;
  logic [7:0]  wdata0 = '0, wdata1 = '0;
  logic [7:0]  rdata0, rdata1, o_data, i_data;
  logic        done0, done1, o_we, busy;
  logic [31:0] o_address;

  logic [7:0]  ram [0:1023];
  logic [7:0]  s1 = '0, s2 = '0;
  int          n_pass = 0, n_chk = 0;
  int          d0_cnt = 0, d1_cnt = 0;

  logic        pk_r0 = 0, pk_r1 = 0, pk_lg = 0, pk_rr = 0, pk_vld, pk_port;

  mem_arbiter #(.ADDR_W(32), .READ_LAT(2), .RR(1)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0), .rdata0(rdata0), .done0(done0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1), .rdata1(rdata1), .done1(done1),
    .o_address(o_address), .o_data(o_data), .o_we(o_we), .i_data(i_data), .busy(busy)
  );

  mem_rr_pick u_pick (
    .req0_i(pk_r0), .req1_i(pk_r1), .last_grant_i(pk_lg), .rr_i(pk_rr),
    .gnt_vld_o(pk_vld), .gnt_port_o(pk_port)
  );

  always #5 clock = ~clock;

  // Memory: data for an address appears two cycles after it is driven.
  always @(posedge clock) begin
    if (o_we) ram[o_address[11:2]] <= o_data;
    s1 <= ram[o_address[11:2]];
    s2 <= s1;
  end
  assign i_data = s2;

  always @(negedge clock) begin
    if (done0) d0_cnt++;
    if (done1) d1_cnt++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Issue one access starting this cycle; latency is counted in cycles to done.
  task automatic run(input bit p, input bit we, input logic [31:0] a, input logic [7:0] wd,
                     input int exp_lat, input logic [7:0] exp_rd, input string tag);
    int lat;
    lat = 99;
    if (!p) begin req0 = 1; we0 = we; addr0 = a; wdata0 = wd; end
    else    begin req1 = 1; we1 = we; addr1 = a; wdata1 = wd; end
    for (int k = 1; k <= 12; k++) begin
      tick();
      if ((!p && done0) || (p && done1)) begin lat = k; break; end
    end
    req0 = 0; req1 = 0;
    chk({tag, " latency"}, lat, exp_lat);
    if (!we) chk({tag, " rdata"}, p ? rdata1 : rdata0, exp_rd);
    tick();
    chk({tag, " busy after"}, busy, 0);
  endtask

  logic [31:0] h0, h1, hw, hd;
  logic [15:0] got_vld, got_port, exp_vld, exp_port;
  logic [3:0]  sel;
  int          nw, snap;

  initial begin
    #2 reset_n = 0;
    tick(); tick();
    chk("rst o_address", o_address, 0);
    chk("rst o_data", o_data, 0);
    chk("rst o_we", o_we, 0);
    chk("rst busy", busy, 0);
    chk("rst done0", done0, 0);
    chk("rst done1", done1, 0);
    chk("rst rdata0", rdata0, 0);
    chk("rst rdata1", rdata1, 0);
    reset_n = 1;
    tick();

    run(0, 1, 32'h40, 8'h5A, 2, 8'h00, "wr0 40");

    // Single read, cycle by cycle
    snap = d1_cnt;
    req0 = 1; we0 = 0; addr0 = 32'h40;
    tick(); chk("rd N+1 addr", o_address, 32'h40); chk("rd N+1 we", o_we, 0);
    tick(); chk("rd N+2 addr", o_address, 32'h40); chk("rd N+2 done0", done0, 0);
    tick(); chk("rd N+3 addr", o_address, 32'h40); chk("rd N+3 done0", done0, 0);
    tick(); chk("rd N+4 done0", done0, 1); chk("rd N+4 rdata0", rdata0, 8'h5A);
    req0 = 0;
    tick(); chk("rd N+5 done0", done0, 0); chk("rd N+5 busy", busy, 0);
    chk("rd rdata0 held", rdata0, 8'h5A);
    chk("rd no done1", d1_cnt - snap, 0);

    // Single write on port 1
    req1 = 1; we1 = 1; addr1 = 32'h100; wdata1 = 8'hC3;
    tick(); chk("wr N+1 we", o_we, 1); chk("wr N+1 data", o_data, 8'hC3);
    chk("wr N+1 addr", o_address, 32'h100); chk("wr N+1 done1", done1, 0);
    req1 = 0; we1 = 0;
    tick(); chk("wr N+2 done1", done1, 1); chk("wr N+2 we", o_we, 0);
    tick(); chk("wr N+3 busy", busy, 0);
    run(0, 0, 32'h100, 8'h00, 4, 8'hC3, "rd0 100");
    chk("rdata1 untouched", rdata1, 0);

    // Contention from reset, round-robin
    reset_n = 0; tick(); reset_n = 1; tick();
    h0 = '0; h1 = '0;
    req0 = 1; we0 = 0; addr0 = 32'h40;
    req1 = 1; we1 = 0; addr1 = 32'h100;
    for (int k = 1; k <= 20; k++) begin
      tick();
      h0[k] = done0;
      h1[k] = done1;
    end
    req0 = 0; req1 = 0;
    chk("rr done0 cycles", h0, 32'h0000_4010);
    chk("rr done1 cycles", h1, 32'h0008_0200);
    chk("rr rdata0", rdata0, 8'h5A);
    chk("rr rdata1", rdata1, 8'hC3);
    tick(); chk("rr busy after", busy, 0);

    // Grant picker, all 16 input combinations, index {rr,lg,r1,r0}
    exp_vld  = 16'hEEEE;
    exp_port = 16'h4C44;
    for (int i = 0; i < 16; i++) begin
      sel = i[3:0];
      {pk_rr, pk_lg, pk_r1, pk_r0} = sel;
      #1;
      got_vld[i]  = pk_vld;
      got_port[i] = pk_port;
    end
    chk("pick vld table", got_vld, exp_vld);
    chk("pick port table", got_port, exp_port);

    // Back-to-back writes with req0 held
    hw = '0; hd = '0; nw = 0;
    req0 = 1; we0 = 1; addr0 = 32'h200; wdata0 = 8'hA0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      hw[k] = o_we;
      hd[k] = done0;
      if (o_we) begin
        chk("b2b o_data", o_data, 8'(8'hA0 + nw));
        nw++;
      end
      if (done0) begin
        wdata0 = wdata0 + 8'd1;
        if (k >= 11) req0 = 0;
      end
    end
    req0 = 0; we0 = 0;
    chk("b2b we cycles", hw, 32'h0000_0492);
    chk("b2b done cycles", hd, 32'h0000_0924);
    chk("b2b busy end", busy, 0);
    run(1, 0, 32'h200, 8'h00, 4, 8'hA3, "rd1 200");

    // Reset during WAIT of a read
    req0 = 1; we0 = 0; addr0 = 32'h40;
    tick(); tick();
    chk("mid-rd busy", busy, 1);
    reset_n = 0; #1;
    chk("mid-rd rst o_we", o_we, 0);
    chk("mid-rd rst busy", busy, 0);
    chk("mid-rd rst done0", done0, 0);
    chk("mid-rd rst rdata0", rdata0, 0);
    req0 = 0;
    snap = d0_cnt;
    tick(); tick(); reset_n = 1; tick(); tick(); tick();
    chk("mid-rd no done0", d0_cnt - snap, 0);

    // Reset during the write strobe: the write must not land
    req1 = 1; we1 = 1; addr1 = 32'h40; wdata1 = 8'hEE;
    tick(); chk("mid-wr o_we", o_we, 1);
    reset_n = 0; #1;
    chk("mid-wr rst o_we", o_we, 0);
    req1 = 0; we1 = 0;
    tick(); reset_n = 1; tick(); tick();
    run(0, 0, 32'h40, 8'h00, 4, 8'h5A, "rd0 after rst");

    // Request dropped in BUS still completes
    req1 = 1; we1 = 0; addr1 = 32'h100;
    tick(); req1 = 0;
    tick(); tick(); tick();
    chk("drop done1", done1, 1);
    chk("drop rdata1", rdata1, 8'hC3);
    tick();
    chk("drop busy", busy, 0);
    chk("drop done1 low", done1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
